// File: rtl/enc_tx_pkg.sv
// enc_tx_pkg
// Shared definitions for the 8b/10b transmit scheduler:
//   - K-symbol byte codes used for comma, start-of-packet and end-of-packet
//   - scheduler state encoding
//   - running-disparity update from the encoder's 10-bit output symbol
package enc_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle / sync
  localparam logic [7:0] K27_7 = 8'hFB;  // start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // end of packet

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_CTL,
    ST_SOP,
    ST_PAYLOAD,
    ST_EOP
  } tx_state_t;

  typedef struct packed {
    logic err;  // symbol was not disparity-legal
    logic rd;   // running disparity after the symbol, 0 = RD-
  } rd_upd_t;

  // Six ones leave the line at RD+, four at RD-, five is neutral.
  // Any other weight cannot come from a legal encoder: keep RD and flag it.
  function automatic rd_upd_t rd_from_symbol(input logic [9:0] sym,
                                             input logic       rd_prev);
    logic [3:0] ones;
    rd_upd_t    upd;
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, sym[i]};
    end
    upd.err = 1'b0;
    upd.rd  = rd_prev;
    case (ones)
      4'd6:    upd.rd  = 1'b1;
      4'd4:    upd.rd  = 1'b0;
      4'd5:    upd.rd  = rd_prev;
      default: upd.err = 1'b1;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/enc_rd_tracker.sv
// enc_rd_tracker
// Tracks running disparity from the encoder's registered output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_enc_data_out    10-bit symbol the encoder produced last cycle
//   o_rd_eff          RD to use for the symbol issued this cycle
//   o_disp_err        the observed symbol had an illegal weight
module enc_rd_tracker
  import enc_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_enc_data_out,
  output logic       o_rd_eff,
  output logic       o_disp_err
);

  logic    r_issued;
  logic    r_rd;
  rd_upd_t w_upd;

  assign w_upd = rd_from_symbol(i_enc_data_out, r_rd);

  // Until the first symbol has gone through the encoder, its output is
  // meaningless, so the stored RD (RD- after reset) is used unmodified.
  assign o_rd_eff   = r_issued ? w_upd.rd : r_rd;
  assign o_disp_err = r_issued & w_upd.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_issued <= 1'b1;
      r_rd     <= o_rd_eff;
    end
  end

endmodule

// File: rtl/enc_tx_ctrl.sv
// enc_tx_ctrl
// Transmit-side symbol scheduler feeding an 8b/10b encoder. Emits a K28.5
// sync preamble after reset, then K28.5 idles, one-shot control K-symbols
// and SOP/payload/EOP framed packets. Tracks running disparity from the
// encoder's registered output and latches encoder/disparity errors.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pkt_valid/pkt_data/pkt_last    payload byte stream
//   pkt_ready                      payload byte consumed this cycle
//   ctl_req/ctl_code               control K-symbol request (level)
//   ctl_ack                        control symbol issued this cycle
//   enc_data_in/enc_k_in/enc_disp_in  symbol to the encoder
//   enc_data_out/enc_k_err         encoder registered output and K error
//   sync_done                      sync preamble complete
//   rd_out                         current effective running disparity
//   err_sticky/err_clr             {disparity err, K err}, and clear
module enc_tx_ctrl
  import enc_tx_pkg::*;
#(
  parameter int SYNC_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  output logic       pkt_ready,
  input  logic       ctl_req,
  input  logic [7:0] ctl_code,
  output logic       ctl_ack,
  output logic [7:0] enc_data_in,
  output logic       enc_k_in,
  output logic       enc_disp_in,
  input  logic [9:0] enc_data_out,
  input  logic       enc_k_err,
  output logic       sync_done,
  output logic       rd_out,
  output logic [1:0] err_sticky,
  input  logic       err_clr
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

  tx_state_t  r_state;
  logic [7:0] r_sync_cnt;
  logic       r_sync_done;
  logic [1:0] r_err;
  logic       w_rd_eff;
  logic       w_disp_err;

  enc_rd_tracker u_rd (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enc_data_out (enc_data_out),
    .o_rd_eff       (w_rd_eff),
    .o_disp_err     (w_disp_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SYNC;
      r_sync_cnt  <= '0;
      r_sync_done <= 1'b0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (r_sync_cnt == SYNC_LAST) begin
            r_state     <= ST_IDLE;
            r_sync_done <= 1'b1;
          end else begin
            r_sync_cnt <= r_sync_cnt + 8'd1;
          end
        end
        // Control requests take priority over a waiting packet.
        ST_IDLE: begin
          if (ctl_req)        r_state <= ST_CTL;
          else if (pkt_valid) r_state <= ST_SOP;
        end
        // Always return through IDLE so a comma follows every control symbol.
        ST_CTL:     r_state <= ST_IDLE;
        ST_SOP:     r_state <= ST_PAYLOAD;
        ST_PAYLOAD: if (pkt_valid && pkt_last) r_state <= ST_EOP;
        ST_EOP:     r_state <= ST_IDLE;
        default:    r_state <= ST_SYNC;
      endcase
    end
  end

  // A new error in the same cycle as err_clr still gets recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 2'b00;
    end else begin
      r_err <= (err_clr ? 2'b00 : r_err) | {w_disp_err, enc_k_err};
    end
  end

  always_comb begin
    enc_data_in = K28_5;
    enc_k_in    = 1'b1;
    pkt_ready   = 1'b0;
    ctl_ack     = 1'b0;
    case (r_state)
      ST_CTL: begin
        enc_data_in = ctl_code;
        ctl_ack     = 1'b1;
      end
      ST_SOP: enc_data_in = K27_7;
      // Underrun inside a frame is filled with K28.5.
      ST_PAYLOAD: begin
        if (pkt_valid) begin
          enc_data_in = pkt_data;
          enc_k_in    = 1'b0;
          pkt_ready   = 1'b1;
        end
      end
      ST_EOP:  enc_data_in = K29_7;
      default: enc_data_in = K28_5;
    endcase
  end

  assign enc_disp_in = w_rd_eff;
  assign rd_out      = w_rd_eff;
  assign sync_done   = r_sync_done;
  assign err_sticky  = r_err;

endmodule

// File: tb/tb_enc_tx_ctrl.sv
// Testbench for enc_tx_ctrl. A small encoder stand-in returns a
// disparity-legal 10-bit symbol chosen by disp_in and reports K errors for
// codes outside the 8b/10b K set. Stimulus pushes the hand-computed
// per-cycle expectation into a queue; a negedge monitor pops and compares.
module tb_enc_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_valid, pkt_last, pkt_ready;
  logic [7:0] pkt_data;
  logic       ctl_req, ctl_ack;
  logic [7:0] ctl_code;
  logic [7:0] enc_data_in;
  logic       enc_k_in, enc_disp_in;
  logic [9:0] enc_data_out;
  logic       enc_k_err;
  logic       sync_done, rd_out, err_clr;
  logic [1:0] err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  enc_tx_ctrl #(.SYNC_LEN(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_valid    (pkt_valid),
    .pkt_data     (pkt_data),
    .pkt_last     (pkt_last),
    .pkt_ready    (pkt_ready),
    .ctl_req      (ctl_req),
    .ctl_code     (ctl_code),
    .ctl_ack      (ctl_ack),
    .enc_data_in  (enc_data_in),
    .enc_k_in     (enc_k_in),
    .enc_disp_in  (enc_disp_in),
    .enc_data_out (enc_data_out),
    .enc_k_err    (enc_k_err),
    .sync_done    (sync_done),
    .rd_out       (rd_out),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr)
  );

  // Encoder stand-in: K28.5-like weight 6 at RD-, weight 4 at RD+.
  logic       force_pop3;
  logic [9:0] enc_q;
  logic       kerr_q;

  function automatic logic k_ok(input logic [7:0] c);
    return (c[4:0] == 5'b11100) || (c == 8'hF7) || (c == 8'hFB) ||
           (c == 8'hFD) || (c == 8'hFE);
  endfunction

  always @(posedge clk) begin
    enc_q  <= enc_disp_in ? 10'b1100000101 : 10'b0011111010;
    kerr_q <= enc_k_in && !k_ok(enc_data_in);
  end
  assign enc_data_out = force_pop3 ? 10'b0000000111 : enc_q;
  assign enc_k_err    = kerr_q;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       k, rdy, ack, rd, sd;
    logic [1:0] err;
  } exp_t;
  exp_t sb[$];

  int   cyc_id = 0;
  logic first;     // next checked cycle is the first after reset release
  logic rd_m;      // RD expected on the previous cycle
  logic exp_sd;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({enc_data_in, enc_k_in, pkt_ready, ctl_ack, rd_out, sync_done, err_sticky} !==
          {e.d, e.k, e.rdy, e.ack, e.rd, e.sd, e.err}) begin
        n_fail++;
        $display("FAIL cyc%0d: got d=%h k=%b rdy=%b ack=%b rd=%b sd=%b err=%b, expected d=%h k=%b rdy=%b ack=%b rd=%b sd=%b err=%b",
                 e.id, enc_data_in, enc_k_in, pkt_ready, ctl_ack, rd_out, sync_done, err_sticky,
                 e.d, e.k, e.rdy, e.ack, e.rd, e.sd, e.err);
      end
    end
  end

  // Expected RD: RD- on the first cycle, then it flips each cycle because the
  // stand-in encoder always answers with the opposite weight; a forced
  // illegal symbol holds it.
  task automatic cyc(input logic [7:0] d, input logic k, input logic rdy,
                     input logic ack, input logic [1:0] err);
    exp_t e;
    e.id  = cyc_id;
    e.d   = d;
    e.k   = k;
    e.rdy = rdy;
    e.ack = ack;
    e.sd  = exp_sd;
    e.err = err;
    e.rd  = first ? 1'b0 : (force_pop3 ? rd_m : ~rd_m);
    rd_m  = e.rd;
    first = 1'b0;
    cyc_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_data"}, int'(enc_data_in), 'hBC);
    chk({tag, "_k"},    int'(enc_k_in), 1);
    chk({tag, "_disp"}, int'(enc_disp_in), 0);
    chk({tag, "_rdy"},  int'(pkt_ready), 0);
    chk({tag, "_ack"},  int'(ctl_ack), 0);
    chk({tag, "_sd"},   int'(sync_done), 0);
    chk({tag, "_rd"},   int'(rd_out), 0);
    chk({tag, "_err"},  int'(err_sticky), 0);
  endtask

  task automatic sync_preamble();
    first  = 1'b1;
    exp_sd = 1'b0;
    for (int i = 0; i < 16; i++) cyc(8'hBC, 1'b1, 1'b0, 1'b0, 2'b00);
    exp_sd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_data = 8'h00; pkt_last = 1'b0;
    ctl_req = 1'b0; ctl_code = 8'h00; err_clr = 1'b0; force_pop3 = 1'b0;
    first = 1'b1; rd_m = 1'b0; exp_sd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;

    // Preamble, then idles.
    sync_preamble();
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Two-byte packet, no underrun.
    pkt_valid = 1; pkt_data = 8'h12; pkt_last = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hFB, 1, 0, 0, 2'b00);
    cyc(8'h12, 0, 1, 0, 2'b00);
    pkt_data = 8'h34; pkt_last = 1;
    cyc(8'h34, 0, 1, 0, 2'b00);
    pkt_valid = 0; pkt_last = 0;
    cyc(8'hFD, 1, 0, 0, 2'b00);
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Underrun of three cycles inside a frame.
    pkt_valid = 1; pkt_data = 8'hA1;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hFB, 1, 0, 0, 2'b00);
    cyc(8'hA1, 0, 1, 0, 2'b00);
    pkt_valid = 0;
    for (int i = 0; i < 3; i++) cyc(8'hBC, 1, 0, 0, 2'b00);
    pkt_valid = 1; pkt_data = 8'hA2; pkt_last = 1;
    cyc(8'hA2, 0, 1, 0, 2'b00);
    pkt_valid = 0; pkt_last = 0;
    cyc(8'hFD, 1, 0, 0, 2'b00);
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Control request and packet pending together: control wins.
    ctl_req = 1; ctl_code = 8'h7C; pkt_valid = 1; pkt_data = 8'h55; pkt_last = 1;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'h7C, 1, 0, 1, 2'b00);
    ctl_req = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hFB, 1, 0, 0, 2'b00);
    cyc(8'h55, 0, 1, 0, 2'b00);
    pkt_valid = 0; pkt_last = 0;
    cyc(8'hFD, 1, 0, 0, 2'b00);
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Invalid K code: K error latched, then cleared.
    ctl_req = 1; ctl_code = 8'h05;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'h05, 1, 0, 1, 2'b00);
    ctl_req = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hBC, 1, 0, 0, 2'b01);
    err_clr = 1;
    cyc(8'hBC, 1, 0, 0, 2'b01);
    err_clr = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // K error arriving together with err_clr is kept.
    ctl_req = 1;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'h05, 1, 0, 1, 2'b00);
    ctl_req = 0; err_clr = 1;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    err_clr = 0;
    cyc(8'hBC, 1, 0, 0, 2'b01);
    err_clr = 1;
    cyc(8'hBC, 1, 0, 0, 2'b01);
    err_clr = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Illegal-weight symbol: RD held, disparity error latched.
    force_pop3 = 1;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    force_pop3 = 0;
    cyc(8'hBC, 1, 0, 0, 2'b10);
    err_clr = 1;
    cyc(8'hBC, 1, 0, 0, 2'b10);
    err_clr = 0;
    cyc(8'hBC, 1, 0, 0, 2'b00);

    // Reset in the middle of a packet.
    pkt_valid = 1; pkt_data = 8'h77;
    cyc(8'hBC, 1, 0, 0, 2'b00);
    cyc(8'hFB, 1, 0, 0, 2'b00);
    cyc(8'h77, 0, 1, 0, 2'b00);
    pkt_data = 8'h78;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    pkt_valid = 0;
    rst_n = 1'b1;
    sync_preamble();
    for (int i = 0; i < 3; i++) cyc(8'hBC, 1, 0, 0, 2'b00);

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
